// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: main-decode FSM, ALU decode and PC enables,
// with a memory ready handshake, wait timeout and illegal-opcode trap.
module mc_control_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 16,
    parameter int STATE_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               pcen,
    output logic [1:0]         memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [2:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic [1:0]         ltype,
    output logic               illegal,
    output logic               bus_err,
    output logic [STATE_W-1:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BREX    = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int CNT_W = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 1;
    localparam logic TO_EN = (TIMEOUT > 32'sd0) && (MEM_HANDSHAKE != 32'sd0);

    function automatic logic is_load(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_LB) || (o == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] o);
        return (o == OP_SW) || (o == OP_SB);
    endfunction

    function automatic logic [1:0] load_type(input logic [5:0] o);
        case (o)
            OP_LB:   return 2'b01;
            OP_LBU:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             rdy_s;
    logic             wait_state_s;
    logic             timeout_s;
    logic             kill_s;

    assign rdy_s        = (MEM_HANDSHAKE != 32'sd0) ? mem_ready : 1'b1;
    assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign timeout_s    = TO_EN && wait_state_s && !rdy_s &&
                          (wait_cnt_r == CNT_W'(TIMEOUT - 32'sd1));
    // Anything that must suppress enables this cycle.
    assign kill_s       = reset || timeout_s;
    assign state        = STATE_W'(state_r);

    // Next-state decode; a timed-out wait abandons the instruction and refetches.
    always_comb begin
        next_state_s = S_FETCH;
        if (timeout_s) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:   next_state_s = rdy_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: next_state_s = S_MEMADR;
                        OP_RTYPE:                           next_state_s = S_RTYPEEX;
                        OP_BEQ, OP_BNE:                     next_state_s = S_BREX;
                        OP_ADDI, OP_ANDI, OP_ORI:           next_state_s = S_IMMEX;
                        OP_J:                               next_state_s = S_JEX;
                        default:                            next_state_s = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (is_store(op)) begin
                        next_state_s = S_MEMWR;
                    end else if (is_load(op)) begin
                        next_state_s = S_MEMRD;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_MEMRD:   next_state_s = rdy_s ? S_MEMWB : S_MEMRD;
                S_MEMWR:   next_state_s = rdy_s ? S_FETCH : S_MEMWR;
                S_RTYPEEX: next_state_s = S_RTYPEWB;
                S_IMMEX:   next_state_s = S_IMMWB;
                default:   next_state_s = S_FETCH;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Consecutive not-ready cycles spent in the current wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (timeout_s || rdy_s || !wait_state_s || (next_state_s != state_r)) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (TO_EN) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Moore control word; FETCH enables follow rdy, RTYPEEX ALU op follows funct.
    always_comb begin
        mem_req    = 1'b0;
        pcen       = 1'b0;
        memwrite   = 2'b00;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 3'b000;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        ltype      = 2'b00;
        illegal    = 1'b0;
        bus_err    = timeout_s && !reset;
        case (state_r)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 3'b001;
                pcen    = rdy_s && !kill_s;
                irwrite = rdy_s && !kill_s;
            end
            S_DECODE: begin
                alusrcb = 3'b011;
                illegal = !reset && !(is_load(op) || is_store(op) ||
                          (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                          (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_J));
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                ltype   = load_type(op);
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                ltype    = load_type(op);
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (kill_s) begin
                    memwrite = 2'b00;
                end else if (op == OP_SB) begin
                    memwrite = 2'b10;
                end else begin
                    memwrite = 2'b01;
                end
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu(funct);
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BREX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                if (op == OP_BEQ) begin
                    pcen = zero;
                end else if (op == OP_BNE) begin
                    pcen = !zero;
                end else begin
                    pcen = 1'b0;
                end
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                case (op)
                    OP_ANDI: begin
                        alusrcb    = 3'b100;
                        alucontrol = ALU_AND;
                    end
                    OP_ORI: begin
                        alusrcb    = 3'b100;
                        alucontrol = ALU_OR;
                    end
                    default: begin
                        alusrcb    = 3'b010;
                        alucontrol = ALU_ADD;
                    end
                endcase
            end
            S_IMMWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm: an instruction-level
// model plans the expected state walk and control word for every cycle.
module tb_mc_control_fsm;

    localparam int TO = 4;

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, pcen, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] memwrite, pcsrc, ltype;
    logic [2:0] alusrcb, alucontrol;
    logic       illegal, bus_err;
    logic [4:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   st;
        logic rdy;
        logic berr;
    } cyc_t;
    cyc_t plan[$];

    mc_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT(TO), .STATE_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pcen(pcen), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .ltype(ltype), .illegal(illegal), .bus_err(bus_err),
        .state(state)
    );

    always #5 clk = ~clk;

    wire [21:0] act = {mem_req, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                       alusrca, alusrcb, pcsrc, alucontrol, ltype, illegal, bus_err};

    // Instruction class: 0 load, 1 store, 2 R-type, 3 branch, 4 immediate, 5 jump, 6 illegal.
    function automatic int iclass(input logic [5:0] o);
        case (o)
            LW, LB, LBU:      return 0;
            SW, SB:           return 1;
            RT:               return 2;
            BEQ, BNE:         return 3;
            ADDI, ANDI, ORI:  return 4;
            JMP:              return 5;
            default:          return 6;
        endcase
    endfunction

    // What the datapath must be told to do in a given step of an instruction.
    function automatic logic [21:0] exp_word(input int st, input logic [5:0] o, input logic [5:0] f,
                                             input logic z, input logic rdy, input logic berr,
                                             input logic rst);
        logic mr, pe, iw, rw, io, mt, rd, sa, il, be;
        logic [1:0] mw, ps, lt;
        logic [2:0] sb, ac;
        {mr, pe, iw, rw, io, mt, rd, sa, il, be} = 10'd0;
        mw = 2'b00; ps = 2'b00; lt = 2'b00; sb = 3'b000; ac = 3'b010;
        case (st)
            0: begin mr = 1'b1; sb = 3'b001; pe = rdy; iw = rdy; end
            1: begin sb = 3'b011; il = (iclass(o) == 6); end
            2: begin sa = 1'b1; sb = 3'b010; end
            3: begin mr = 1'b1; io = 1'b1; lt = (o == LB) ? 2'b01 : (o == LBU) ? 2'b10 : 2'b00; end
            4: begin rw = 1'b1; mt = 1'b1; lt = (o == LB) ? 2'b01 : (o == LBU) ? 2'b10 : 2'b00; end
            5: begin mr = 1'b1; io = 1'b1; mw = (o == SB) ? 2'b10 : 2'b01; end
            6: begin
                sa = 1'b1;
                case (f)
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'b010;
                endcase
            end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = (o == BEQ) ? z : !z; end
            9: begin
                sa = 1'b1;
                if (o == ANDI) begin sb = 3'b100; ac = 3'b000; end
                else if (o == ORI) begin sb = 3'b100; ac = 3'b001; end
                else sb = 3'b010;
            end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        if (berr) begin pe = 1'b0; iw = 1'b0; mw = 2'b00; be = 1'b1; end
        if (rst) begin pe = 1'b0; iw = 1'b0; rw = 1'b0; mw = 2'b00; il = 1'b0; be = 1'b0; end
        return {mr, pe, mw, iw, rw, io, mt, rd, sa, sb, ps, ac, lt, il, be};
    endfunction

    // A memory step with w not-ready cycles: either completes or times out on cycle TO.
    task automatic add_mem(input int st, input int w, output bit aborted);
        aborted = 1'b0;
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) plan.push_back('{st, 1'b0, (i == TO - 1)});
            aborted = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) plan.push_back('{st, 1'b0, 1'b0});
            plan.push_back('{st, 1'b1, 1'b0});
        end
    endtask

    task automatic add_plain(input int st);
        plan.push_back('{st, 1'(($urandom & 32'd1) != 32'd0), 1'b0});
    endtask

    // Plan one instruction from its class, then run it, checking every cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm);
        bit ab;
        plan.delete();
        op = o; funct = f; zero = z;
        add_mem(0, wf, ab);
        if (!ab) begin
            add_plain(1);
            case (iclass(o))
                0: begin add_plain(2); add_mem(3, wm, ab); if (!ab) add_plain(4); end
                1: begin add_plain(2); add_mem(5, wm, ab); end
                2: begin add_plain(6); add_plain(7); end
                3: add_plain(8);
                4: begin add_plain(9); add_plain(10); end
                5: add_plain(11);
                default: ;
            endcase
        end
        foreach (plan[i]) begin
            logic [21:0] e;
            mem_ready = plan[i].rdy;
            @(negedge clk);
            e = exp_word(plan[i].st, o, f, z, plan[i].rdy, plan[i].berr, 1'b0);
            checks++;
            if ((state !== 5'(plan[i].st)) || (act !== e)) begin
                errors++;
                $display("FAIL instr op=%b funct=%b step %0d: state %0d word %h, expected state %0d word %h",
                         o, f, i, state, act, plan[i].st, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; op = LW; funct = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mem_ready = (k == 0);
            #1;
            checks++;
            if ((state !== 5'd0) || (act !== exp_word(0, op, funct, zero, mem_ready, 1'b0, 1'b1))) begin
                errors++;
                $display("FAIL reset rdy=%0b: state %0d word %h, expected 0 %h", mem_ready, state, act,
                         exp_word(0, op, funct, zero, mem_ready, 1'b0, 1'b1));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        run_instr(ADDI, 6'd0, 1'b0, 0, 0);
    endtask

    task automatic test_lb_wait();
        run_instr(LB, 6'd0, 1'b0, 0, 3);
        run_instr(LBU, 6'd0, 1'b0, 1, 0);
    endtask

    task automatic test_branch();
        run_instr(BNE, 6'd0, 1'b0, 0, 0);
        run_instr(BNE, 6'd0, 1'b1, 0, 0);
        run_instr(BEQ, 6'd0, 1'b1, 0, 0);
        run_instr(BEQ, 6'd0, 1'b0, 2, 0);
    endtask

    task automatic test_rtype();
        run_instr(RT, 6'b101010, 1'b0, 0, 0);
        run_instr(RT, 6'b111111, 1'b0, 0, 0);
        run_instr(RT, 6'b100010, 1'b0, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr(SB, 6'd0, 1'b0, 0, TO);
        run_instr(SB, 6'd0, 1'b0, 0, TO - 1);
        run_instr(LW, 6'd0, 1'b0, 0, TO + 2);
        run_instr(JMP, 6'd0, 1'b0, TO, 0);
        run_instr(JMP, 6'd0, 1'b0, TO - 1, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
        run_instr(ANDI, 6'd0, 1'b0, 0, 0);
        run_instr(ORI, 6'd0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        op = LW; funct = 6'd0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        checks++;
        if (state !== 5'd3) begin
            errors++;
            $display("FAIL reset_mid setup: state %0d, expected 3", state);
        end
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ((state !== 5'd0) || (act !== exp_word(0, op, funct, zero, 1'b1, 1'b0, 1'b1))) begin
            errors++;
            $display("FAIL reset_mid: state %0d word %h, expected 0 %h", state, act,
                     exp_word(0, op, funct, zero, 1'b1, 1'b0, 1'b1));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(SW, 6'd0, 1'b0, 0, 1);
    endtask

    task automatic test_random();
        logic [5:0] ops [12] = '{LW, LB, LBU, SW, SB, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};
        logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] o;
            int wf, wm;
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : 0;
            wm = $urandom_range(0, TO + 1);
            run_instr(o, functs[$urandom_range(0, 5)], 1'($urandom), wf, wm);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lb_wait();
        test_branch();
        test_rtype();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        @(negedge clk);
        checks++;
        if (state !== 5'd0) begin
            errors++;
            $display("FAIL final_state: state %0d, expected 0", state);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
